// File: rtl/adat_frame_encoder_if.sv
// adat_frame_encoder_if: frame RAM read port, frame index, user nibble and line/status outputs of the ADAT encoder
interface adat_frame_encoder_if #(
    parameter int CIRC_BUF_BITS = 3
);
    logic                     ram_data_i;
    logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i;
    logic [3:0]               user_bits_i;
    logic [CIRC_BUF_BITS+7:0] ram_read_addr_o;
    logic                     adat_o;
    logic                     frame_start_o;
    logic                     active_o;
    logic                     underrun_o;
    logic [15:0]              drop_count_o;
    modport master (
        input  ram_data_i, last_good_frame_idx_i, user_bits_i,
        output ram_read_addr_o, adat_o, frame_start_o, active_o, underrun_o, drop_count_o
    );
    modport slave (
        output ram_data_i, last_good_frame_idx_i, user_bits_i,
        input  ram_read_addr_o, adat_o, frame_start_o, active_o, underrun_o, drop_count_o
    );
endinterface

// File: rtl/adat_frame_encoder.sv
// adat_frame_encoder: bit-serial ADAT frame builder with NRZI line coding; ADAT_ENCODER_STATS_EN adds a saturating drop counter
module adat_frame_encoder #(
    parameter int CIRC_BUF_BITS = 3,
    parameter int SAMPLE_BITS   = 24,
    parameter int NUM_CHANNELS  = 8,
    parameter int MISS_LIMIT    = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    adat_frame_encoder_if.master bus
);
    typedef enum logic {IDLE, DATA} state_t;
    state_t                   state, state_n;
    logic [CIRC_BUF_BITS-1:0] read_frame, read_frame_n;
    logic [2:0]               missed, missed_n;
    logic [7:0]               pos;
    logic [2:0]               ph, ph_n;
    logic [2:0]               ch;
    logic [4:0]               idx;
    logic [3:0]               user_q;
    logic                     mask_q, adat_q, underrun_q, underrun_n;
    logic                     last_pos, adv, avail, enc;

    assign last_pos = pos == 8'd255;
    assign adv      = (pos < 8'd239) && (ph != 3'd4);
    assign ph_n     = (last_pos || ph == 3'd4) ? 3'd0 : ph + 3'd1;
    assign avail    = bus.last_good_frame_idx_i != read_frame;

    // Frame decision state: mode, frame being replayed, consecutive misses, underrun pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            read_frame <= '0;
            missed     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_n;
            read_frame <= read_frame_n;
            missed     <= missed_n;
            underrun_q <= underrun_n;
        end
    end

    // Frame switch happens only at the last position; a miss in DATA replays the previous frame
    always_comb begin
        state_n      = state;
        read_frame_n = read_frame;
        missed_n     = missed;
        underrun_n   = 1'b0;
        if (last_pos && avail) begin
            state_n      = DATA;
            read_frame_n = bus.last_good_frame_idx_i;
            missed_n     = '0;
        end else if (last_pos && state == DATA) begin
            underrun_n = 1'b1;
            state_n    = (missed == 3'(MISS_LIMIT - 1)) ? IDLE : DATA;
            missed_n   = (missed == 3'(MISS_LIMIT - 1)) ? 3'd0 : missed + 3'd1;
        end
    end

    // Position/nibble phase, read address of the next data bit, its mask, user latch and NRZI line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos    <= '0;
            ph     <= '0;
            ch     <= '0;
            idx    <= '0;
            mask_q <= 1'b0;
            user_q <= '0;
            adat_q <= 1'b0;
        end else begin
            pos    <= pos + 8'd1;
            ph     <= ph_n;
            if (last_pos)
                {ch, idx} <= '0;
            else if (adv)
                {ch, idx} <= (idx == 5'd23) ? {ch + 3'd1, 5'd0} : {ch, idx + 5'd1};
            mask_q <= ({1'b0, ch} < 4'(NUM_CHANNELS)) && ({1'b0, idx} < 6'(SAMPLE_BITS));
            if (pos == 8'd250)
                user_q <= bus.user_bits_i;
            adat_q <= adat_q ^ enc;
        end
    end

    // Bit to send at the current position: nibble sync '1', masked data, sync pattern, user nibble
    always_comb begin
        enc = 1'b0;
        enc = (pos < 8'd240) ? ((ph == 3'd0) | (state == DATA & mask_q & bus.ram_data_i)) :
              (pos == 8'd240 || pos == 8'd251) ? 1'b1 :
              (pos >= 8'd252) ? user_q[pos[1:0]] : 1'b0;
    end

    assign bus.ram_read_addr_o = {read_frame, ch, idx};
    assign bus.adat_o          = adat_q;
    assign bus.frame_start_o   = (pos == 8'd0) & ~rst_i;
    assign bus.active_o        = state == DATA;
    assign bus.underrun_o      = underrun_q;

`ifdef ADAT_ENCODER_STATS_EN
    logic [15:0] drop_q;
    // Saturating count of underruns, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i)
            drop_q <= '0;
        else if (underrun_n && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
    end
    assign bus.drop_count_o = drop_q;
`else
    assign bus.drop_count_o = 16'h0000;
`endif
endmodule

// File: tb/tb_adat_frame_encoder.sv
// tb_adat_frame_encoder: frame-by-frame checks of a full-width and a narrowed encoder sharing one frame RAM
module tb_adat_frame_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef ADAT_ENCODER_STATS_EN
    localparam logic [15:0] EXP_DROP = 16'd5;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    adat_frame_encoder_if #(.CIRC_BUF_BITS(3)) bus_a ();
    adat_frame_encoder_if #(.CIRC_BUF_BITS(3)) bus_b ();

    adat_frame_encoder #(.CIRC_BUF_BITS(3)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    adat_frame_encoder #(.CIRC_BUF_BITS(3), .SAMPLE_BITS(16), .NUM_CHANNELS(2)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    logic mem [0:2047];

    // One-cycle-latency frame RAM
    always @(posedge clk) begin
        bus_a.ram_data_i <= mem[bus_a.ram_read_addr_o];
        bus_b.ram_data_i <= mem[bus_b.ram_read_addr_o];
    end

    int   checks = 0;
    int   errors = 0;
    logic prev_a, prev_b;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic [2:0] idx, input logic [3:0] usr);
        bus_a.last_good_frame_idx_i = idx;
        bus_b.last_good_frame_idx_i = idx;
        bus_a.user_bits_i = usr;
        bus_b.user_bits_i = usr;
    endtask

    // Reference frame in transmit order; slot data stored MSB first at bit index 0
    function automatic logic [255:0] exp_frame(input logic act, input int rf, input logic [3:0] usr,
                                               input int sb, input int nc);
        logic [255:0] f;
        int n, c, bi;
        f = '0;
        for (int p = 0; p < 240; p++) begin
            n  = p / 5;
            c  = n / 6;
            bi = (n % 6) * 4 + p % 5 - 1;
            f[p] = (p % 5 == 0) ? 1'b1 : (act && c < nc && bi < sb && mem[rf * 256 + c * 32 + bi]);
        end
        f[240] = 1'b1;
        f[251] = 1'b1;
        for (int k = 0; k < 4; k++) f[252 + k] = usr[k];
        return f;
    endfunction

    // Address of the first data position after p
    function automatic logic [10:0] exp_addr(input int rf, input int p);
        int q;
        q = p + 1;
        if (q % 5 == 0) q++;
        if (q >= 240) return 11'(rf * 256);
        return 11'(rf * 256 + (q / 30) * 32 + ((q / 5) % 6) * 4 + q % 5 - 1);
    endfunction

    // Capture one frame starting at the negedge of a pos-0 cycle, NRZI-decoding both line outputs
    task automatic grab(input int rf, input int chg_pos, input logic [3:0] chg_user,
                        output logic [255:0] fa, output logic [255:0] fb,
                        output logic [1:0] ur0, output logic [1:0] act_mid, output int errs);
        errs = 0;
        ur0 = '0;
        act_mid = '0;
        fa = '0;
        fb = '0;
        for (int i = 0; i < 256; i++) begin
            if (bus_a.ram_read_addr_o !== exp_addr(rf, i)) errs++;
            if (bus_b.ram_read_addr_o !== exp_addr(rf, i)) errs++;
            if (bus_a.frame_start_o !== (i == 0)) errs++;
            if (bus_b.frame_start_o !== (i == 0)) errs++;
            if (i == 0) ur0 = {bus_a.underrun_o, bus_b.underrun_o};
            else if (bus_a.underrun_o !== 1'b0 || bus_b.underrun_o !== 1'b0) errs++;
            if (i == 128) act_mid = {bus_a.active_o, bus_b.active_o};
            if (i == chg_pos) begin
                bus_a.user_bits_i = chg_user;
                bus_b.user_bits_i = chg_user;
            end
            @(negedge clk);
            fa[i] = bus_a.adat_o ^ prev_a;
            fb[i] = bus_b.adat_o ^ prev_b;
            prev_a = bus_a.adat_o;
            prev_b = bus_b.adat_o;
        end
    endtask

    typedef struct {
        logic [2:0] idx;
        logic [3:0] user;
        logic       act;
        int         rf;
        logic       ur;
    } rec_t;

    rec_t tbl [10];

    initial begin
        logic [255:0] fa, fb;
        logic [1:0]   ur0, am;
        logic [23:0]  s1, s2;
        int           errs;
        // idx driven during the frame, user nibble, expected active, slot in force, underrun at frame start
        tbl[0] = '{3'd0, 4'h3, 1'b0, 0, 1'b0};
        tbl[1] = '{3'd0, 4'hC, 1'b0, 0, 1'b0};
        tbl[2] = '{3'd1, 4'h5, 1'b0, 0, 1'b0};
        tbl[3] = '{3'd2, 4'hA, 1'b1, 1, 1'b0};
        tbl[4] = '{3'd2, 4'h6, 1'b1, 2, 1'b0};
        tbl[5] = '{3'd2, 4'h9, 1'b1, 2, 1'b1};
        tbl[6] = '{3'd2, 4'hF, 1'b1, 2, 1'b1};
        tbl[7] = '{3'd2, 4'h0, 1'b1, 2, 1'b1};
        tbl[8] = '{3'd2, 4'hE, 1'b1, 2, 1'b1};
        tbl[9] = '{3'd2, 4'h1, 1'b0, 2, 1'b1};
        for (int a = 0; a < 2048; a++) mem[a] = 1'($urandom);
        for (int c = 0; c < 8; c++) begin
            s1 = 24'hA5A5A0 + 24'(c);
            s2 = 24'h3C5A96 ^ (24'(c) * 24'h111111);
            for (int b = 0; b < 24; b++) begin
                mem[256 + c * 32 + b] = s1[23 - b];
                mem[512 + c * 32 + b] = s2[23 - b];
            end
        end
        drive(3'd0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", {bus_a.adat_o, bus_a.frame_start_o, bus_a.active_o, bus_a.underrun_o,
                          bus_a.ram_read_addr_o, bus_a.drop_count_o}, '0);
        check("reset_b", {bus_b.adat_o, bus_b.frame_start_o, bus_b.active_o, bus_b.underrun_o,
                          bus_b.ram_read_addr_o, bus_b.drop_count_o}, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        prev_a = bus_a.adat_o;
        prev_b = bus_b.adat_o;

        for (int f = 0; f < 10; f++) begin
            drive(tbl[f].idx, tbl[f].user);
            grab(tbl[f].rf, -1, 4'h0, fa, fb, ur0, am, errs);
            check($sformatf("f%0d_frame_a", f), fa, exp_frame(tbl[f].act, tbl[f].rf, tbl[f].user, 24, 8));
            check($sformatf("f%0d_frame_b", f), fb, exp_frame(tbl[f].act, tbl[f].rf, tbl[f].user, 16, 2));
            check($sformatf("f%0d_underrun", f), ur0, {2{tbl[f].ur}});
            check($sformatf("f%0d_active", f), am, {2{tbl[f].act}});
            check($sformatf("f%0d_timing", f), errs, 0);
        end

        check("drop_count", {bus_a.drop_count_o, bus_b.drop_count_o}, {EXP_DROP, EXP_DROP});

        // User nibble latched at pos 250; the change at 251 must not reach the line
        drive(3'd2, 4'b1011);
        grab(2, 251, 4'b0100, fa, fb, ur0, am, errs);
        check("user_bits", fa[255:252], 4'b1011);
        check("idle_frame_a", fa, exp_frame(1'b0, 2, 4'b1011, 24, 8));
        check("idle_no_underrun", ur0, 2'b00);
        check("idle_timing", errs, 0);

        // One-cycle reset at pos 100 of the next frame
        drive(3'd2, 4'h7);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_adat", {bus_a.adat_o, bus_b.adat_o}, 2'b00);
        check("rst_frame_start", {bus_a.frame_start_o, bus_b.frame_start_o}, 2'b11);
        check("rst_state", {bus_a.active_o, bus_b.active_o, bus_a.drop_count_o, bus_b.drop_count_o}, '0);
        prev_a = bus_a.adat_o;
        prev_b = bus_b.adat_o;
        grab(0, -1, 4'h0, fa, fb, ur0, am, errs);
        check("post_rst_frame_a", fa, exp_frame(1'b0, 0, 4'h7, 24, 8));
        check("post_rst_timing", errs, 0);
        drive(3'd2, 4'h2);
        grab(2, -1, 4'h0, fa, fb, ur0, am, errs);
        check("post_rst_data_a", fa, exp_frame(1'b1, 2, 4'h2, 24, 8));
        check("post_rst_data_b", fb, exp_frame(1'b1, 2, 4'h2, 16, 2));
        check("post_rst_active", am, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
